// File: rtl/basic_ram.sv
// basic_ram: single-port RAM with synchronous write and asynchronous (combinational) read.
// One shared address bus serves both read and write. A synchronous reset clears every word.
module basic_ram #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] in,
  output logic [DATA_WIDTH-1:0] out
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] mem_d [Depth];

  // Next-state: only the addressed word changes, and only when we is high.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[addr] = in;
    end
  end

  // Storage: reset overrides any write on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read path is a pure mux, so a write becomes visible only after the edge.
  assign out = mem_q[addr];

endmodule

// File: tb/tb_basic_ram.sv
// Directed self-checking bench for basic_ram.
module tb_basic_ram;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] out;

  int checks = 0;
  int errors = 0;

  basic_ram #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .addr (addr),
    .in   (din),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] exp);
    checks++;
    assert (out === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, out, exp);
    end
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    we   = 1'b1;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic reset_edge();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    we    = 1'b0;
    addr  = '0;
    din   = '0;

    // Reset state: every word reads zero.
    reset_edge();
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1;
      check($sformatf("reset_state[%0d]", i), 8'h00);
    end

    // Basic write / combinational read-back.
    write(4'd0, 8'h81);
    write(4'd1, 8'hEA);
    write(4'd2, 8'hFF);
    @(negedge clk);
    addr = 4'd0; #1; check("readback_0", 8'h81);
    addr = 4'd1; #1; check("readback_1", 8'hEA);
    addr = 4'd2; #1; check("readback_2", 8'hFF);

    // Reset clear after filling with 0xA5.
    for (int i = 0; i < 16; i++) write(4'(i), 8'hA5);
    addr = 4'd9; #1; check("fill_a5", 8'hA5);
    reset_edge();
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1;
      check($sformatf("reset_clear[%0d]", i), 8'h00);
    end

    // Reset wins over a simultaneous write.
    write(4'd3, 8'hA5);
    @(negedge clk);
    rst_n = 1'b0;
    we    = 1'b1;
    addr  = 4'd3;
    din   = 8'hFF;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    we    = 1'b0;
    check("reset_over_write", 8'h00);

    // Write enable gating.
    write(4'd7, 8'h3C);
    din = 8'h99;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("we_gate[%0d]", i), 8'h3C);
    end

    // Read-during-write on the same address.
    write(4'd4, 8'h11);
    @(negedge clk);
    we   = 1'b1;
    addr = 4'd4;
    din  = 8'h22;
    #1;
    check("rdw_before", 8'h11);
    @(posedge clk);
    #1;
    we = 1'b0;
    check("rdw_after", 8'h22);

    // Boundary addresses and neighbours.
    write(4'd1, 8'h12);
    write(4'd14, 8'h34);
    write(4'd0, 8'h5A);
    write(4'd15, 8'hC3);
    addr = 4'd0;  #1; check("bound_0", 8'h5A);
    addr = 4'd15; #1; check("bound_15", 8'hC3);
    addr = 4'd1;  #1; check("bound_1_kept", 8'h12);
    addr = 4'd14; #1; check("bound_14_kept", 8'h34);

    // Reset pulse between edges must have no effect.
    @(negedge clk);
    addr = 4'd15;
    #1;
    rst_n = 1'b0;
    #1;
    check("pulse_during", 8'hC3);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    addr = 4'd0;  #1; check("pulse_0", 8'h5A);
    addr = 4'd15; #1; check("pulse_15", 8'hC3);
    addr = 4'd7;  #1; check("pulse_7", 8'h3C);
    addr = 4'd4;  #1; check("pulse_4", 8'h22);
    addr = 4'd14; #1; check("pulse_14", 8'h34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
